// File: rtl/segment_pkg.sv
// segment_pkg: shared seven-segment glyph table and segment bit-order constants
package segment_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int NUM_SEGS = 7;
  localparam int NUM_GLYPHS = 32;
  typedef enum logic [4:0] {
    CODE_BLANK  = 5'd16,
    CODE_DASH   = 5'd17,
    CODE_H      = 5'd18,
    CODE_L      = 5'd19,
    CODE_P      = 5'd20,
    CODE_U      = 5'd21,
    CODE_R      = 5'd22,
    CODE_N      = 5'd23,
    CODE_O      = 5'd24,
    CODE_Y      = 5'd25,
    CODE_J      = 5'd26,
    CODE_UNDER  = 5'd27,
    CODE_EQUALS = 5'd28,
    CODE_OVER   = 5'd29,
    CODE_DEGREE = 5'd30,
    CODE_LAMP   = 5'd31
  } code_e;
  // Active-high {g,f,e,d,c,b,a} patterns, listed from code 31 down to code 0.
  localparam logic [NUM_GLYPHS-1:0][NUM_SEGS-1:0] GLYPH_TABLE = {
    7'h7F, 7'h63, 7'h01, 7'h48, 7'h08, 7'h1E, 7'h6E, 7'h5C,
    7'h54, 7'h50, 7'h3E, 7'h73, 7'h38, 7'h76, 7'h40, 7'h00,
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [NUM_SEGS-1:0] glyph(input logic [4:0] code);
    return GLYPH_TABLE[code];
  endfunction
endpackage

// File: rtl/segment_glyph_rom.sv
// segment_glyph_rom: 5-bit symbol code to active-high 7-segment pattern
module segment_glyph_rom
  import segment_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] pattern
);
  assign pattern = glyph(code);
endmodule

// File: rtl/binary_to_segment.sv
// binary_to_segment: registered seven-segment driver with blank override and polarity select
module binary_to_segment
  import segment_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] seven_in,
  input  logic       blank,
  output logic [6:0] seven_out
);
  logic [6:0] pattern;
  logic [6:0] drive;
  segment_glyph_rom u_rom (
    .code    (seven_in),
    .pattern (pattern)
  );
  assign drive = (blank ? 7'h00 : pattern) ^ {NUM_SEGS{ACTIVE_LOW}};
  // Output register; reset drives the dark pattern for the selected polarity.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) seven_out <= {NUM_SEGS{ACTIVE_LOW}};
    else seven_out <= drive;
endmodule

// File: tb/tb_binary_to_segment.sv
// tb_binary_to_segment: scoreboard bench for both output polarities
module tb_binary_to_segment;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] seven_in = 5'd0;
  logic       blank = 1'b0;
  logic [6:0] out_hi_dark;
  logic [6:0] out_lo_dark;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic [6:0] al;
    logic [6:0] ah;
  } exp_t;
  exp_t sb[$];
  logic [6:0] tbl [32] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
    7'h00, 7'h40, 7'h76, 7'h38, 7'h73, 7'h3E, 7'h50, 7'h54,
    7'h5C, 7'h6E, 7'h1E, 7'h08, 7'h48, 7'h01, 7'h63, 7'h7F
  };

  binary_to_segment #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk       (clk),
    .rst_n     (rst_n),
    .seven_in  (seven_in),
    .blank     (blank),
    .seven_out (out_hi_dark)
  );
  binary_to_segment #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk       (clk),
    .rst_n     (rst_n),
    .seven_in  (seven_in),
    .blank     (blank),
    .seven_out (out_lo_dark)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] code, input logic b);
    exp_t e;
    @(negedge clk);
    seven_in = code;
    blank = b;
    e.ah = b ? 7'h00 : tbl[code];
    e.al = ~e.ah;
    sb.push_back(e);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_empty"}, 7'h00, 7'h7F);
    end else begin
      e = sb.pop_front();
      check({tag, "_al"}, out_hi_dark, e.al);
      check({tag, "_ah"}, out_lo_dark, e.ah);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] code, input logic b);
    drive(code, b);
    collect(tag);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_async_al", out_hi_dark, 7'h7F);
    check("reset_async_ah", out_lo_dark, 7'h00);
    @(posedge clk);
    #1;
    check("reset_hold_al", out_hi_dark, 7'h7F);
    drive(5'd8, 1'b0);
    rst_n = 1'b1;
    collect("reset_release");
    for (int i = 0; i < 32; i++) step($sformatf("sweep%0d", i), 5'(i), 1'b0);
    step("blank_on", 5'd8, 1'b1);
    step("blank_off", 5'd8, 1'b0);
    step("blank_lamp", 5'd31, 1'b1);
    step("pol_a", 5'd10, 1'b0);
    step("pol_16", 5'd16, 1'b0);
    step("glitch_3", 5'd3, 1'b0);
    check("glitch_pre_al", out_hi_dark, 7'h30);
    drive(5'd5, 1'b0);
    #2;
    check("glitch_hold_al", out_hi_dark, 7'h30);
    collect("glitch_5");
    check("glitch_new_al", out_hi_dark, 7'h12);
    step("mid_1", 5'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_al", out_hi_dark, 7'h7F);
    check("mid_reset_ah", out_lo_dark, 7'h00);
    @(posedge clk);
    #1;
    check("mid_reset_hold_al", out_hi_dark, 7'h7F);
    check("mid_reset_hold_ah", out_lo_dark, 7'h00);
    drive(5'd2, 1'b0);
    rst_n = 1'b1;
    collect("mid_release");
    for (int i = 0; i < 8; i++) step($sformatf("rand%0d", i), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    check("sb_drained", 7'(sb.size()), 7'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
